ram_rsp: RTL and testbench

RAM_RSP -- requirements
Module: ram_rsp

---
 rtl/ram_rsp_pkg.sv | 20 ++
 rtl/ram_rsp_mem.sv | 29 ++
 rtl/ram_rsp.sv | 122 ++++++++++++
 tb/tb_ram_rsp.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/ram_rsp_pkg.sv
// Shared configuration for the ram_rsp block: bus-width macros, FSM state
// encoding and default read latency.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package ram_rsp_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int RD_LAT_DEF = 2;
  // Wide enough for RD_LAT-1 with RD_LAT up to 7.
  localparam int CNT_W = 3;
endpackage

// File: rtl/ram_rsp_mem.sv
// Byte-masked word storage: synchronous masked write, combinational read.
// Contents are intentionally not reset.
module ram_rsp_mem #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 1024,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                    i_clk,
  input  logic                    i_we,
  input  logic [IDX_W-1:0]        i_widx,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wmask,
  input  logic [IDX_W-1:0]        i_ridx,
  output logic [DATA_WIDTH-1:0]   o_rdata
);
  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < NB; b++) begin
        if (i_wmask[b]) mem_q[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = mem_q[i_ridx];
endmodule

// File: rtl/ram_rsp.sv
// Single-outstanding RAM front end: accepts read/write requests, writes commit
// on the accepting edge, reads answer after RD_LAT cycles and hold until taken.
module ram_rsp
  import ram_rsp_pkg::*;
#(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int DEPTH      = 1024,
  parameter int RD_LAT     = RD_LAT_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_ram_rd_en,
  input  logic [`ADDR_WIDTH-1:0]  i_ram_rd_addr,
  input  logic                    i_ram_wr_en,
  input  logic [`ADDR_WIDTH-1:0]  i_ram_wr_addr,
  input  logic [DATA_WIDTH-1:0]   i_ram_wr_data,
  input  logic [DATA_WIDTH/8-1:0] i_ram_wr_mask,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [DATA_WIDTH-1:0]   o_ram_rd_data,
  output logic                    o_err
);
  localparam int BYTE_W = $clog2(DATA_WIDTH / 8);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int TOP_LO = IDX_W + BYTE_W;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    oor_q, oor_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    err_q, err_d;

  logic [IDX_W-1:0]        rd_idx, wr_idx;
  logic                    rd_oor, wr_oor, mem_we;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    unused_offset;

  assign rd_idx = i_ram_rd_addr[TOP_LO-1:BYTE_W];
  assign wr_idx = i_ram_wr_addr[TOP_LO-1:BYTE_W];
  // Any set bit above the word index makes the address out of range.
  assign rd_oor = (i_ram_rd_addr >> TOP_LO) != '0;
  assign wr_oor = (i_ram_wr_addr >> TOP_LO) != '0;
  assign unused_offset = ^{i_ram_rd_addr[BYTE_W-1:0], i_ram_wr_addr[BYTE_W-1:0]};

  assign o_ready = (state_q == IDLE);
  assign o_valid = (state_q == RESP);
  assign o_ram_rd_data = data_q;
  assign o_err = err_q;
  assign mem_we = o_ready && i_valid && i_ram_wr_en && !wr_oor;

  ram_rsp_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W)
  ) u_mem (
    .i_clk  (i_clk),
    .i_we   (mem_we),
    .i_widx (wr_idx),
    .i_wdata(i_ram_wr_data),
    .i_wmask(i_ram_wr_mask),
    .i_ridx (idx_q),
    .o_rdata(mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    oor_d   = oor_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (i_valid && i_ram_rd_en) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(RD_LAT - 1);
          idx_d   = rd_idx;
          oor_d   = rd_oor;
        end
      end
      WAIT: begin
        // Array is sampled late, so a write in the same request is visible.
        if (cnt_q == '0) begin
          state_d = RESP;
          data_d  = oor_q ? '0 : mem_rdata;
          err_d   = oor_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (i_ready) begin
          state_d = IDLE;
          data_d  = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      oor_q   <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      oor_q   <= oor_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_ram_rsp.sv
// Directed plus randomized checks of ram_rsp against a word-array reference model.
module tb_ram_rsp;
  localparam int DW  = 64;
  localparam int DEP = 1024;
  localparam int LAT = 2;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_valid = 1'b0;
  logic            o_ready;
  logic            i_ram_rd_en = 1'b0;
  logic [31:0]     i_ram_rd_addr = '0;
  logic            i_ram_wr_en = 1'b0;
  logic [31:0]     i_ram_wr_addr = '0;
  logic [DW-1:0]   i_ram_wr_data = '0;
  logic [DW/8-1:0] i_ram_wr_mask = '0;
  logic            o_valid;
  logic            i_ready = 1'b0;
  logic [DW-1:0]   o_ram_rd_data;
  logic            o_err;

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] mdl [DEP];

  ram_rsp #(.DATA_WIDTH(DW), .DEPTH(DEP), .RD_LAT(LAT)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_ram_rd_en(i_ram_rd_en), .i_ram_rd_addr(i_ram_rd_addr),
    .i_ram_wr_en(i_ram_wr_en), .i_ram_wr_addr(i_ram_wr_addr),
    .i_ram_wr_data(i_ram_wr_data), .i_ram_wr_mask(i_ram_wr_mask),
    .o_valid(o_valid), .i_ready(i_ready), .o_ram_rd_data(o_ram_rd_data),
    .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: a byte-addressed word store with range check on the upper bits.
  function automatic bit in_range(input logic [31:0] a);
    return a < 32'(DEP * (DW / 8));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a % 32'(DEP * (DW / 8))) / 32'(DW / 8));
  endfunction

  // One request; if it reads, check latency, held response (stall cycles) and release.
  task automatic req(input bit rd, input logic [31:0] ra, input bit wr, input logic [31:0] wa,
                     input logic [DW-1:0] wd, input logic [DW/8-1:0] wm, input int stall,
                     input bit checks);
    logic [DW-1:0] exp_d;
    bit exp_e;
    int n;
    n = 0;
    while (!o_ready && n < 20) begin @(posedge i_clk); #1; n++; end
    if (checks) chk("ready_before_req", o_ready, 1);
    i_valid = 1; i_ram_rd_en = rd; i_ram_rd_addr = ra;
    i_ram_wr_en = wr; i_ram_wr_addr = wa; i_ram_wr_data = wd; i_ram_wr_mask = wm;
    @(posedge i_clk); #1;
    i_valid = 0; i_ram_rd_en = 0; i_ram_wr_en = 0;
    if (wr && in_range(wa))
      for (int b = 0; b < DW / 8; b++)
        if (wm[b]) mdl[widx(wa)][8*b +: 8] = wd[8*b +: 8];
    if (!rd) return;
    exp_e = !in_range(ra);
    exp_d = exp_e ? '0 : mdl[widx(ra)];
    n = 0;
    while (!o_valid && n < 20) begin
      chk("idle_wait_data_zero", o_ram_rd_data, '0);
      @(posedge i_clk); #1; n++;
    end
    chk("read_latency", DW'(n), DW'(LAT));
    for (int s = 0; s <= stall; s++) begin
      chk("resp_valid", o_valid, 1);
      chk("resp_data", o_ram_rd_data, exp_d);
      chk("resp_err", o_err, exp_e);
      chk("resp_ready_low", o_ready, 0);
      if (s < stall) begin @(posedge i_clk); #1; end
    end
    i_ready = 1;
    @(posedge i_clk); #1;
    i_ready = 0;
    chk("release_valid_low", o_valid, 0);
    chk("release_ready_high", o_ready, 1);
    chk("release_data_zero", o_ram_rd_data, '0);
    chk("release_err_zero", o_err, 0);
  endtask

  initial begin
    logic [31:0] ra, wa;
    logic [DW-1:0] wd;
    // Reset state
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_ram_rd_data, '0);
    chk("rst_err", o_err, 0);
    repeat (2) @(posedge i_clk);
    #1 i_rst = 0;
    chk("rst_ready_after", o_ready, 1);

    // Bring the array to a known all-zero state.
    for (int i = 0; i < DEP; i++) begin
      mdl[i] = '0;
      req(0, 0, 1, 32'(i * 8), '0, '1, 0, 0);
    end

    // Full write, full read; then one-byte patch read through a nonzero offset.
    req(0, 0, 1, 32'h40, 64'h1122334455667788, 8'hFF, 0, 1);
    req(1, 32'h40, 0, 0, '0, '0, 0, 1);
    req(0, 0, 1, 32'h40, 64'h00000000000000AA, 8'h01, 0, 1);
    req(1, 32'h47, 0, 0, '0, '0, 0, 1);
    chk("patched_word_model", mdl[8], 64'h11223344556677AA);
    // Back-pressure for 5 cycles
    req(1, 32'h40, 0, 0, '0, '0, 5, 1);
    // Out of range read and dropped write
    req(1, 32'h2000, 0, 0, '0, '0, 0, 1);
    req(0, 0, 1, 32'h2000, '1, 8'hFF, 0, 1);
    req(1, 32'h0, 0, 0, '0, '0, 0, 1);
    // Write-before-read in one request, same and differing addresses
    req(1, 32'h80, 1, 32'h80, 64'hDEADBEEF, 8'h0F, 0, 1);
    req(1, 32'h40, 1, 32'h88, 64'h55AA55AA55AA55AA, 8'hF0, 0, 1);
    req(1, 32'h88, 0, 0, '0, '0, 0, 1);
    // Mask zero is a no-op
    req(0, 0, 1, 32'h40, '1, 8'h00, 0, 1);
    req(1, 32'h40, 0, 0, '0, '0, 0, 1);

    // Reset one cycle after accepting a read discards it.
    i_valid = 1; i_ram_rd_en = 1; i_ram_rd_addr = 32'h40;
    @(posedge i_clk); #1;
    i_valid = 0; i_ram_rd_en = 0;
    @(posedge i_clk); #1;
    i_rst = 1;
    #3;
    chk("rst_mid_valid", o_valid, 0);
    @(posedge i_clk); #1;
    i_rst = 0;
    for (int k = 0; k < LAT + 4; k++) begin
      chk("no_resp_after_rst", o_valid, 0);
      chk("ready_after_rst", o_ready, 1);
      @(posedge i_clk); #1;
    end
    req(1, 32'h40, 0, 0, '0, '0, 0, 1);
    req(1, 32'h80, 0, 0, '0, '0, 0, 1);

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      ra = {$urandom_range(0, DEP - 1), 3'($urandom)};
      wa = {$urandom_range(0, DEP - 1), 3'($urandom)};
      if ($urandom_range(0, 7) == 0) ra = ra | (32'h1 << $urandom_range(13, 31));
      if ($urandom_range(0, 7) == 0) wa = wa | (32'h1 << $urandom_range(13, 31));
      wd = {$urandom, $urandom};
      req(1'($urandom), ra, 1'($urandom), wa, wd, 8'($urandom), $urandom_range(0, 3), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
